cache_bus_arbiter: RTL and testbench
====================================

Name: cache_bus_arbiter

Overview:
- Round-robin arbiter sharing the single memory/bus port between the per-core caches.
- Each cache raises its req_arb line on a miss and holds it until its transfer finishes; the arbiter returns a one-hot grant.
- Enforces one owner at a time, a one-cycle turnaround between owners, and a hold-time watchdog so a hung cache cannot lock the bus.

Parameters:
- NUM_REQ, 4, number of requesting caches (2..8).
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release (>=2).
- ID_W, 2, width of gnt_id; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-cache bus request (the caches' req_arb).
- done  input  NUM_REQ  per-cache one-cycle pulse marking the end of its transfer.
- gnt  output  NUM_REQ  one-hot grant (drives the caches' gnt_arb); all zero when no owner.
- gnt_valid  output  1  high when any gnt bit is high.
- gnt_id  output  ID_W  index of the current owner; holds the last owner when gnt_valid=0.
- timeout_err  output  1  one-cycle pulse when a grant is force-released by the watchdog.

Behaviour:
- Reset: gnt=0, gnt_valid=0, gnt_id=0, timeout_err=0, hold counter=0, state=IDLE.
- Reset sets the priority pointer last=NUM_REQ-1, so requester 0 wins first.
- Reset mid-grant drops gnt immediately (asynchronous). No transfer state survives reset.
- State machine: IDLE, BUSY, TURN. All outputs are registered.
- Arbitration, evaluated in IDLE and TURN: search for the first set req bit starting at index last+1 and wrapping modulo NUM_REQ.
  - If a winner w exists: next state BUSY; gnt=1<<w, gnt_id=w, gnt_valid=1, and counter=0 after the edge.
  - If no bit is set: stay in or go to IDLE with gnt=0.
- Latency: a req sampled high at edge k in IDLE gives gnt high after edge k. Minimum req-to-gnt latency is one cycle.
- BUSY, owner o: gnt held stable and the counter increments every cycle. Release conditions:
  - done[o]=1 or req[o]=0: next state TURN, gnt=0, last=o.
  - counter==MAX_HOLD-1 with no release condition: next state TURN, gnt=0, last=o, and timeout_err=1 for exactly the following cycle.
  - done[o] and timeout in the same cycle: treat as a normal release, timeout_err=0.
- Ignored inputs:
  - done bits from non-owners are ignored in all states.
  - A done pulse in IDLE or TURN is ignored.
- TURN: gnt=0 for exactly one cycle (bus turnaround). It arbitrates as above using the updated last, so a second requester is granted after the TURN cycle.
- Fairness: with all NUM_REQ requests continuously high, grants rotate 0,1,2,…,NUM_REQ-1,0.
  - Worst-case wait for any requester: (NUM_REQ-1)*(MAX_HOLD+1) cycles.
- A released requester that keeps req high re-wins only when no other req is set; it is lowest priority after its own release.
- Invariants:
  - gnt is zero or one-hot at every cycle.
  - gnt_valid == |gnt.
  - gnt[gnt_id]==1 whenever gnt_valid.

Test Plan:
- Reset, then req=4'b0100 held → gnt=4'b0100, gnt_id=2 one cycle later. done[2] pulse → gnt=0 for 1 cycle (TURN), then IDLE.
- req=4'b1111 constant, each owner pulses done 3 cycles after grant → grant order 0,1,2,3,0. Each grant separated by one gnt=0 cycle.
- req=4'b0001 held with no done, MAX_HOLD=16 → gnt[0] high exactly 16 cycles, then gnt=0 and timeout_err=1 for one cycle. req still high → regrant to 0 after the TURN cycle.
- Owner 1 drops req without done while req[3]=1 → TURN one cycle, then gnt=4'b1000.
- done[2] pulsed while owner is 0 → ignored, gnt stays 4'b0001. done[0] coincident with counter==15 → release with timeout_err=0.
- rst asserted mid-BUSY (owner 3) between clock edges → gnt=0 immediately. After deassert with req=4'b1010 → first grant to 1.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// Round-robin owner selection for the shared memory bus, with a one-cycle
// turnaround between owners and a hold-time watchdog on every grant.
module cache_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    last_q, last_d;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    cand;
    logic               owner_release;
    logic               hold_expired;

    // Search starts just past the previous owner, so it becomes lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_q) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign owner_release = done[gnt_id_q] | ~req[gnt_id_q];
    assign hold_expired  = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, TURN: state_d = found ? BUSY : IDLE;
            BUSY:       state_d = (owner_release || hold_expired) ? TURN : BUSY;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d         = '0;
        gnt_valid_d   = 1'b0;
        gnt_id_d      = gnt_id_q;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        last_d        = last_q;
        case (state_q)
            IDLE, TURN: begin
                if (found) begin
                    gnt_d       = NUM_REQ'(1) << win;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = win;
                    cnt_d       = '0;
                end
            end
            BUSY: begin
                if (owner_release || hold_expired) begin
                    last_d        = gnt_id_q;
                    // A real release on the last allowed cycle is not a timeout.
                    timeout_err_d = hold_expired && !owner_release;
                end else begin
                    gnt_d       = gnt_q;
                    gnt_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                last_d = last_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q         <= '0;
            gnt_valid_q   <= 1'b0;
            gnt_id_q      <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
        end else begin
            gnt_q         <= gnt_d;
            gnt_valid_q   <= gnt_valid_d;
            gnt_id_q      <= gnt_id_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_valid   = gnt_valid_q;
    assign gnt_id      = gnt_id_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard bench for cache_bus_arbiter: stimulus queues the expected
// outputs per clock edge, a negedge monitor pops and compares them.
module tb_cache_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         tag;
        string      name;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    cache_bus_arbiter #(
        .NUM_REQ (4),
        .MAX_HOLD(16),
        .ID_W    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive inputs now; their effect appears after the next rising edge.
    task automatic drive_now(input logic [3:0] r, input logic [3:0] d,
                             input logic [3:0] eg, input logic [1:0] eid,
                             input logic ee, input string nm);
        exp_t e;
        req    = r;
        done   = d;
        e.tag  = cyc + 1;
        e.name = nm;
        e.gnt  = eg;
        e.id   = eid;
        e.err  = ee;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] d,
                        input logic [3:0] eg, input logic [1:0] eid,
                        input logic ee, input string nm);
        @(negedge clk);
        drive_now(r, d, eg, eid, ee, nm);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".gnt"}, 32'(gnt), 32'd0);
        check({nm, ".gnt_valid"}, 32'(gnt_valid), 32'd0);
        check({nm, ".gnt_id"}, 32'(gnt_id), 32'd0);
        check({nm, ".timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        done = '0;
        #1;
        check_reset_outputs("rst_pulse");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: invariants every cycle, plus queued expectations when due.
    always @(negedge clk) begin
        check("inv_onehot", 32'($onehot0(gnt)), 32'd1);
        check("inv_valid", 32'(gnt_valid), 32'(|gnt));
        if (gnt_valid) check("inv_owner_bit", 32'(gnt[gnt_id]), 32'd1);
        while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, ".gnt"}, 32'(gnt), 32'(mon_e.gnt));
            check({mon_e.name, ".gnt_valid"}, 32'(gnt_valid), 32'(|mon_e.gnt));
            check({mon_e.name, ".gnt_id"}, 32'(gnt_id), 32'(mon_e.id));
            check({mon_e.name, ".timeout_err"}, 32'(timeout_err), 32'(mon_e.err));
        end
    end

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single requester, release by done, back to idle.
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "a_grant");
        step(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, "a_hold");
        step(4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, "a_turn");
        step(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, "a_idle");

        // All requesting: rotation 0,1,2,3,0 with a gap cycle between owners.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 4'b0000, 4'(1 << k), 2'(k), 1'b0, "b_grant");
            step(4'b1111, 4'b0000, 4'(1 << k), 2'(k), 1'b0, "b_hold1");
            step(4'b1111, 4'b0000, 4'(1 << k), 2'(k), 1'b0, "b_hold2");
            step(4'b1111, 4'(1 << k), 4'b0000, 2'(k), 1'b0, "b_turn");
        end
        step(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, "b_wrap");
        step(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, "b_rel");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "b_idle");

        // Watchdog: 16 cycles of grant, then forced release with error pulse.
        step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "c_grant");
        for (int k = 0; k < 15; k++)
            step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "c_hold");
        step(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1, "c_timeout");
        step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "c_regrant");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "c_drop");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "c_idle");

        // Owner drops req without done; waiting requester 3 follows.
        step(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, "d_grant");
        step(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, "d_hold");
        step(4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b0, "d_drop");
        step(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "d_next");
        step(4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, "d_rel");
        step(4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, "d_idle");

        // Foreign done ignored; done on the last allowed cycle is a clean release.
        step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "e_grant");
        step(4'b0001, 4'b0100, 4'b0001, 2'd0, 1'b0, "e_foreign_done");
        for (int k = 0; k < 14; k++)
            step(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, "e_hold");
        step(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, "e_done_at_limit");
        step(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, "e_turn_idle");
        step(4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, "e_idle_done");

        // Asynchronous reset in the middle of a grant.
        step(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "f_grant");
        step(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, "f_hold");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("f_async_rst");
        req = 4'b1010;
        @(negedge clk);
        rst = 1'b0;
        drive_now(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, "f_first");
        step(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, "f_rel");
        step(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, "f_idle");

        repeat (3) @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
